// File: rtl/ret_addr_stack_pkg.sv
// rs_pkg: shared definitions for the return-address stack.
//   rs_cnt_w()  - width needed to hold an occupancy count of 0..depth
//   rs_op_t     - decoded stack operation for one cycle
//   OP_*        - operation encodings shared by the stack and its controller
package rs_pkg;

  // Occupancy ranges over 0..depth inclusive, hence depth+1 values.
  function automatic int rs_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [1:0] rs_op_t;

  localparam rs_op_t OP_NONE    = 2'd0;
  localparam rs_op_t OP_PUSH    = 2'd1;
  localparam rs_op_t OP_POP     = 2'd2;
  localparam rs_op_t OP_REPLACE = 2'd3;

endpackage

// File: rtl/ret_addr_stack_ptr_ctrl.sv
// rs_ptr_ctrl: next-state logic for the return-address stack pointer/count.
// Decodes push/pop/flush into a single operation, applies the priority and
// overflow policy, and produces the array write strobe plus error-set pulses.
// Ports:
//   push, pop, flush   - requested operations this cycle
//   full, empty        - current occupancy status
//   tp_q, count_q      - current top pointer and occupancy
//   tp_d, count_d      - next top pointer and occupancy
//   we, waddr          - array write enable and index (data is push_data)
//   ovf_set, unf_set   - one-cycle pulses that set the sticky error flags
module rs_ptr_ctrl
  import rs_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WRAP_ON_OVF = 1,
  parameter int PTR_W       = 3,
  parameter int CNT_W       = 4
) (
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             full,
  input  logic             empty,
  input  logic [PTR_W-1:0] tp_q,
  input  logic [CNT_W-1:0] count_q,
  output logic [PTR_W-1:0] tp_d,
  output logic [CNT_W-1:0] count_d,
  output logic             we,
  output logic [PTR_W-1:0] waddr,
  output logic             ovf_set,
  output logic             unf_set
);

  localparam logic [PTR_W-1:0] TP_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] tp_inc;
  logic [PTR_W-1:0] tp_dec;
  rs_op_t           op;

  // Explicit modulo-DEPTH stepping so non-power-of-two depths wrap correctly.
  assign tp_inc = (tp_q == TP_LAST) ? '0 : tp_q + 1'b1;
  assign tp_dec = (tp_q == '0) ? TP_LAST : tp_q - 1'b1;

  // Flush dominates; a push+pop on an empty stack has nothing to replace,
  // so it degrades to a plain push (the underflow is flagged below).
  always_comb begin
    op = OP_NONE;
    if (flush) begin
      op = OP_NONE;
    end else if (push && pop) begin
      op = empty ? OP_PUSH : OP_REPLACE;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop) begin
      op = OP_POP;
    end
  end

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    we      = 1'b0;
    waddr   = tp_inc;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    if (flush) begin
      tp_d    = '0;
      count_d = '0;
    end else begin
      unique case (op)
        OP_REPLACE: begin
          we    = 1'b1;
          waddr = tp_q;
        end
        OP_PUSH: begin
          unf_set = pop;  // only reached with pop=1 when the stack is empty
          if (!full) begin
            tp_d    = tp_inc;
            count_d = count_q + 1'b1;
            we      = 1'b1;
          end else begin
            ovf_set = 1'b1;
            if (WRAP_ON_OVF != 0) begin
              // Overwrite the oldest slot; occupancy stays at DEPTH.
              tp_d = tp_inc;
              we   = 1'b1;
            end
          end
        end
        OP_POP: begin
          if (!empty) begin
            tp_d    = tp_dec;
            count_d = count_q - 1'b1;
          end else begin
            unf_set = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: parametrised return-address stack for the IF/ID stage.
// Holds the entry array, the sticky error flags and the output muxing; the
// pointer/count next-state logic lives in rs_ptr_ctrl.
// Ports:
//   clk, reset        - clock; asynchronous active-high reset
//   push, push_data   - push a return address (CALL)
//   pop               - pop the top entry (RET); push+pop replaces the top
//   flush             - synchronous clear of the stack contents
//   clr_err           - clear both sticky error flags (a same-cycle set wins)
//   top_data          - top entry, 0 when empty (combinational from state)
//   empty, full, count- occupancy status
//   overflow_err      - sticky: push while full
//   underflow_err     - sticky: pop while empty
module ret_addr_stack
  import rs_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 8,
  parameter int WRAP_ON_OVF = 1,
  parameter int CNT_W       = rs_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              flush,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, unf_q;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic              ovf_set, unf_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  rs_ptr_ctrl #(
    .DEPTH       (DEPTH),
    .WRAP_ON_OVF (WRAP_ON_OVF),
    .PTR_W       (PTR_W),
    .CNT_W       (CNT_W)
  ) u_ptr_ctrl (
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .full    (full),
    .empty   (empty),
    .tp_q    (tp_q),
    .count_q (count_q),
    .tp_d    (tp_d),
    .count_d (count_d),
    .we      (we),
    .waddr   (waddr),
    .ovf_set (ovf_set),
    .unf_set (unf_set)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      // Set takes priority over clear so no event is ever lost.
      ovf_q   <= ovf_set | (ovf_q & ~clr_err);
      unf_q   <= unf_set | (unf_q & ~clr_err);
    end
  end

  // Contents are deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= push_data;
    end
  end

  // No write-through: a new top appears only after the edge that stores it.
  assign top_data      = empty ? '0 : mem_q[tp_q];
  assign count         = count_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
module tb_ret_addr_stack;

  localparam int AW = 12;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [AW-1:0] push_data = '0;

  logic [AW-1:0] top_w, top_d;
  logic          emp_w, emp_d, ful_w, ful_d, ovf_w, ovf_d, unf_w, unf_d;
  logic [CW-1:0] cnt_w, cnt_d;

  ret_addr_stack #(.ADDR_W(AW), .DEPTH(DP), .WRAP_ON_OVF(1)) dut_wrap (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .flush(flush), .clr_err(clr_err), .top_data(top_w), .empty(emp_w),
    .full(ful_w), .count(cnt_w), .overflow_err(ovf_w), .underflow_err(unf_w)
  );

  ret_addr_stack #(.ADDR_W(AW), .DEPTH(DP), .WRAP_ON_OVF(0)) dut_drop (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .flush(flush), .clr_err(clr_err), .top_data(top_d), .empty(emp_d),
    .full(ful_d), .count(cnt_d), .overflow_err(ovf_d), .underflow_err(unf_d)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;   // cycle whose negedge checks it; -1 = check now
    int            sel;   // 0 = wrap instance, 1 = drop instance
    logic [AW-1:0] top;
    int            cnt;
    bit            ovf;
    bit            unf;
    string         name;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  // Expectation for the state after the next rising edge; sel 2 = both DUTs.
  task automatic expect_st(input int sel, input logic [AW-1:0] top, input int cnt,
                           input bit ovf, input bit unf, input string nm,
                           input bit now = 1'b0);
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (sel == 2 || sel == s) begin
        e.due = now ? -1 : cyc + 1;
        e.sel = s;
        e.top = top;
        e.cnt = cnt;
        e.ovf = ovf;
        e.unf = unf;
        e.name = nm;
        sb.push_back(e);
      end
    end
    if (now) ->chk_ev;
  endtask

  task automatic drive(input bit pu, input bit po, input logic [AW-1:0] d,
                       input bit fl, input bit ce);
    @(posedge clk);
    #1;
    push = pu; pop = po; push_data = d; flush = fl; clr_err = ce;
  endtask

  // Monitor: compares every expectation that has come due.
  always begin
    @(negedge clk or chk_ev);
    #0;
    while (sb.size() > 0 && (sb[0].due < 0 || sb[0].due <= cyc)) begin
      exp_t e;
      logic [AW-1:0] a_top;
      logic [CW-1:0] a_cnt;
      logic a_emp, a_ful, a_ovf, a_unf;
      logic [AW+CW+3:0] got, want;
      e = sb.pop_front();
      if (e.sel == 0) begin
        a_top = top_w; a_cnt = cnt_w; a_emp = emp_w; a_ful = ful_w; a_ovf = ovf_w; a_unf = unf_w;
      end else begin
        a_top = top_d; a_cnt = cnt_d; a_emp = emp_d; a_ful = ful_d; a_ovf = ovf_d; a_unf = unf_d;
      end
      got  = {a_top, a_cnt, a_emp, a_ful, a_ovf, a_unf};
      want = {e.top, CW'(e.cnt), e.cnt == 0, e.cnt == DP, e.ovf, e.unf};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s dut=%0d: got top=%h cnt=%0d emp=%b full=%b ovf=%b unf=%b, exp top=%h cnt=%0d emp=%b full=%b ovf=%b unf=%b",
                 e.name, e.sel, a_top, a_cnt, a_emp, a_ful, a_ovf, a_unf,
                 e.top, e.cnt, e.cnt == 0, e.cnt == DP, e.ovf, e.unf);
      end else begin
        $display("ok   %s dut=%0d: top=%h cnt=%0d ovf=%b unf=%b", e.name, e.sel,
                 a_top, a_cnt, a_ovf, a_unf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, checked while reset is still asserted.
    #3;
    expect_st(2, 12'h000, 0, 0, 0, "reset_hold", 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    expect_st(2, 12'h000, 0, 0, 0, "reset_idle");

    // 1: basic push/pop
    drive(1, 0, 12'h010, 0, 0); expect_st(2, 12'h010, 1, 0, 0, "t1_push10");
    drive(1, 0, 12'h020, 0, 0); expect_st(2, 12'h020, 2, 0, 0, "t1_push20");
    drive(1, 0, 12'h030, 0, 0); expect_st(2, 12'h030, 3, 0, 0, "t1_push30");
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h020, 2, 0, 0, "t1_pop1");
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h010, 1, 0, 0, "t1_pop2");
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h000, 0, 0, 0, "t1_pop3");

    // 2: overflow, wrap vs drop
    drive(1, 0, 12'h001, 0, 0); expect_st(2, 12'h001, 1, 0, 0, "t2_push1");
    drive(1, 0, 12'h002, 0, 0); expect_st(2, 12'h002, 2, 0, 0, "t2_push2");
    drive(1, 0, 12'h003, 0, 0); expect_st(2, 12'h003, 3, 0, 0, "t2_push3");
    drive(1, 0, 12'h004, 0, 0); expect_st(2, 12'h004, 4, 0, 0, "t2_push4");
    drive(1, 0, 12'h005, 0, 0);
    expect_st(0, 12'h005, 4, 1, 0, "t2_push5_wrap");
    expect_st(1, 12'h004, 4, 1, 0, "t2_push5_drop");
    drive(0, 1, 12'h000, 0, 0);
    expect_st(0, 12'h004, 3, 1, 0, "t2_pop1"); expect_st(1, 12'h003, 3, 1, 0, "t2_pop1");
    drive(0, 1, 12'h000, 0, 0);
    expect_st(0, 12'h003, 2, 1, 0, "t2_pop2"); expect_st(1, 12'h002, 2, 1, 0, "t2_pop2");
    drive(0, 1, 12'h000, 0, 0);
    expect_st(0, 12'h002, 1, 1, 0, "t2_pop3"); expect_st(1, 12'h001, 1, 1, 0, "t2_pop3");
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h000, 0, 1, 0, "t2_pop4");
    drive(0, 0, 12'h000, 0, 1); expect_st(2, 12'h000, 0, 0, 0, "t2_clr");

    // 3: replace top
    drive(1, 0, 12'h100, 0, 0); expect_st(2, 12'h100, 1, 0, 0, "t3_push100");
    drive(1, 0, 12'h200, 0, 0); expect_st(2, 12'h200, 2, 0, 0, "t3_push200");
    drive(1, 1, 12'h2AA, 0, 0); expect_st(2, 12'h2AA, 2, 0, 0, "t3_replace");
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h100, 1, 0, 0, "t3_pop");
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h000, 0, 0, 0, "t3_pop_last");

    // 4: underflow and set-beats-clear
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h000, 0, 0, 1, "t4_unf");
    drive(0, 1, 12'h000, 0, 1); expect_st(2, 12'h000, 0, 0, 1, "t4_set_wins");
    drive(0, 0, 12'h000, 0, 1); expect_st(2, 12'h000, 0, 0, 0, "t4_clr");

    // push+pop on an empty stack acts as a push and flags underflow
    drive(1, 1, 12'h0AB, 0, 0); expect_st(2, 12'h0AB, 1, 0, 1, "pp_empty");
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h000, 0, 0, 1, "pp_pop");
    drive(0, 0, 12'h000, 0, 1); expect_st(2, 12'h000, 0, 0, 0, "pp_clr");

    // 5: flush beats push, leaves error flags alone
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h000, 0, 0, 1, "t5_unf");
    drive(1, 0, 12'h00A, 0, 0); expect_st(2, 12'h00A, 1, 0, 1, "t5_pushA");
    drive(1, 0, 12'h00B, 0, 0); expect_st(2, 12'h00B, 2, 0, 1, "t5_pushB");
    drive(1, 0, 12'h00C, 0, 0); expect_st(2, 12'h00C, 3, 0, 1, "t5_pushC");
    drive(1, 0, 12'hFFF, 1, 0); expect_st(2, 12'h000, 0, 0, 1, "t5_flush");
    drive(0, 0, 12'h000, 0, 1); expect_st(2, 12'h000, 0, 0, 0, "t5_clr");

    // 6: asynchronous reset mid-cycle
    drive(0, 1, 12'h000, 0, 0); expect_st(2, 12'h000, 0, 0, 1, "t6_unf");
    drive(1, 0, 12'h001, 0, 0); expect_st(2, 12'h001, 1, 0, 1, "t6_push1");
    drive(1, 0, 12'h002, 0, 0); expect_st(2, 12'h002, 2, 0, 1, "t6_push2");
    drive(1, 0, 12'h555, 0, 0);
    #6 reset = 1'b1;
    #1 expect_st(2, 12'h000, 0, 0, 0, "t6_async_reset", 1'b1);
    @(posedge clk); #1;
    reset = 1'b0; push = 1'b0;
    drive(1, 0, 12'h7FF, 0, 0); expect_st(2, 12'h7FF, 1, 0, 0, "t6_push7FF");
    drive(0, 0, 12'h000, 0, 0); expect_st(2, 12'h7FF, 1, 0, 0, "t6_idle");

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expectations, exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
Parametrised return-address stack for the pipelined core. It replaces the fixed single-purpose stack. The IF/ID stage pushes the return PC (caller PC + 1) on CALL and pops it on RET. The top entry drives the PC mux "return" leg combinationally. Over the fixed stack it adds:
- configurable depth and width
- simultaneous push/pop (replace top)
- selectable overflow policy (wrap or drop)
- full, empty and count status
- sticky overflow and underflow error flags for the hazard/controller unit
- a flush that clears the stack

Parameters:
ADDR_W, 12, width of a stored return address in bits (the PC width)
DEPTH, 8, number of entries; must be 2 or more; need not be a power of two
WRAP_ON_OVF, 1, 1 = a push when full overwrites the oldest entry; 0 = a push when full is dropped
CNT_W, $clog2(DEPTH+1), width of count (derived; do not override)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  reset, asynchronous, active-high
push  in  1  push push_data this cycle
pop  in  1  pop the top entry this cycle
push_data  in  ADDR_W  return address to push
flush  in  1  synchronous clear of the stack contents
clr_err  in  1  clear both sticky error flags
top_data  out  ADDR_W  current top entry; combinational from state; 0 when empty
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  CNT_W  number of valid entries
overflow_err  out  1  sticky; a push occurred while full
underflow_err  out  1  sticky; a pop occurred while empty

Behaviour:
- State:
  - entry array mem[0..DEPTH-1] of ADDR_W bits
  - top pointer tp in the range 0..DEPTH-1
  - count in the range 0..DEPTH
  - two sticky error flags
- Reset (asynchronous, any cycle, including mid-operation):
  - tp = 0, count = 0, overflow_err = 0, underflow_err = 0
  - mem is not cleared
  - top_data = 0, empty = 1, full = 0
- Pointer arithmetic: inc(tp) = (tp == DEPTH-1) ? 0 : tp+1; dec(tp) = (tp == 0) ? DEPTH-1 : tp-1. This is explicit modulo DEPTH; no reliance on power-of-two wrap.
- top_data = empty ? 0 : mem[tp]. A write is visible on top_data the cycle after the edge; there is no write-through bypass.
- Per-edge priority (highest first):
  1. flush: tp = 0, count = 0. push and pop are ignored that cycle. Error flags are not modified by flush, though clr_err still applies.
  2. push and pop together:
     - not empty: mem[tp] = push_data; tp and count unchanged (replace top, i.e. a RET immediately followed by a CALL).
     - empty: behaves as a plain push; underflow_err is set.
  3. push only:
     - not full: tp = inc(tp), mem[inc(tp)] = push_data, count = count+1.
     - full, WRAP_ON_OVF = 1: tp = inc(tp), mem[inc(tp)] = push_data, count stays DEPTH (the oldest entry is lost); overflow_err is set.
     - full, WRAP_ON_OVF = 0: no state change; overflow_err is set.
  4. pop only:
     - not empty: tp = dec(tp), count = count-1.
     - empty: no state change; underflow_err is set.
- Sticky flags:
  - Set on the events above.
  - Cleared by clr_err.
  - If a set event and clr_err occur in the same cycle, set wins.
- Latency: one cycle from push/pop to the updated top_data, count, full and empty. All outputs are glitch-free functions of registered state.
- Ignore X on push_data when push is 0.

Decomposition:
- Shared package (rs_pkg): derived CNT_W function and an op encoding localparam (NONE, PUSH, POP, REPLACE) used by the stack and the controller.
- Sub-module rs_ptr_ctrl:
  - computes next tp, next count and the write enable/index from push, pop, flush, full and empty.
  - kept separate so the priority and wrap logic can be unit-tested without the array.
- The top level holds the mem array, the sticky flags and the output muxing.

Test Plan:
Bench uses DEPTH=4, ADDR_W=12.
1. Reset, then push 0x010, 0x020, 0x030 on consecutive edges -> count 3, top_data 0x030; three pops -> top_data 0x020, 0x010, then 0 with empty=1; no error flags.
2. Push 0x001..0x005 with WRAP_ON_OVF=1 -> after the 5th push: full=1, count 4, top 0x005, overflow_err=1; 4 pops return 0x005, 0x004, 0x003, 0x002 (0x001 lost). Repeat with WRAP_ON_OVF=0 -> top stays 0x004; pops return 0x004, 0x003, 0x002, 0x001.
3. Stack holds 0x100, 0x200; assert push=1, pop=1 with push_data 0x2AA -> count 2, top 0x2AA; a pop then yields 0x100.
4. Pop when empty -> underflow_err=1, count 0. Next cycle assert clr_err together with another empty pop -> flag stays 1. A following clr_err alone -> flag goes to 0.
5. Stack holds 3 entries; assert flush with push=1 -> count 0, empty=1, top_data 0; the error flags are unchanged.
6. Assert reset asynchronously mid-cycle while count=2 and push is active -> all outputs reach their reset values immediately, without waiting for a clock edge; first push after release of 0x7FF -> count 1, top 0x7FF.
